// File: rtl/slc3_mem_pkg.sv
// Shared types and defaults for the SRAM responder: FSM state encoding,
// bus widths and default timing parameters.
package slc3_mem_pkg;

    localparam int ADDR_W        = 20;
    localparam int DATA_W        = 16;
    localparam int DEF_DEPTH_W   = 8;
    localparam int DEF_READ_LAT  = 2;
    localparam int DEF_WRITE_LAT = 1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_WAIT,
        WR_HOLD
    } state_t;

endpackage

// File: rtl/sram_array.sv
// Single-port word storage with per-byte write enables, synchronous write
// and asynchronous read. No reset: contents are cleared by the owner.
module sram_array #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [1:0]         byte_en,
    input  logic [DEPTH_W-1:0] addr,
    input  logic [15:0]        wdata,
    output logic [15:0]        rdata
);

    logic [15:0] mem [2**DEPTH_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (byte_en[1]) mem[addr][15:8] <= wdata[15:8];
            if (byte_en[0]) mem[addr][7:0]  <= wdata[7:0];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sram_responder.sv
// Asynchronous-SRAM-style responder: clears its storage after reset, then
// serves active-low CE/OE/WE read and write cycles with fixed latencies.
module sram_responder
    import slc3_mem_pkg::*;
#(
    parameter int DEPTH_W   = DEF_DEPTH_W,
    parameter int READ_LAT  = DEF_READ_LAT,
    parameter int WRITE_LAT = DEF_WRITE_LAT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CE,
    input  logic              OE,
    input  logic              WE,
    input  logic              UB,
    input  logic              LB,
    input  logic [ADDR_W-1:0] ADDR,
    inout  wire  [15:0]       Data,
    output logic              Init_done,
    output logic              Rd_valid
);

    localparam logic [2:0] READ_LOAD  = 3'(READ_LAT - 1);
    localparam logic [2:0] WRITE_LOAD = 3'(WRITE_LAT - 1);
    localparam state_t     RD_FIRST   = (READ_LAT == 1) ? RD_DRIVE : RD_WAIT;

    state_t              state, state_d;
    logic [DEPTH_W-1:0]  init_idx, init_idx_d;
    logic [2:0]          wait_cnt, wait_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                commit;

    logic                arr_we;
    logic [1:0]          arr_be;
    logic [DEPTH_W-1:0]  arr_addr;
    logic [15:0]         arr_wdata;
    logic [15:0]         arr_rdata;
    logic                drive;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= INIT;
            init_idx <= '0;
            wait_cnt <= '0;
            addr_q   <= '0;
        end else begin
            state    <= state_d;
            init_idx <= init_idx_d;
            wait_cnt <= wait_cnt_d;
            addr_q   <= addr_d;
        end
    end

    // A start cycle (from IDLE, or a restart from a read state) captures the
    // full 20-bit address so that an aliased address still counts as a change.
    always_comb begin
        state_d    = state;
        init_idx_d = init_idx;
        wait_cnt_d = wait_cnt;
        addr_d     = addr_q;
        commit     = 1'b0;
        case (state)
            INIT: begin
                if (init_idx == '1) begin
                    state_d = IDLE;
                end else begin
                    init_idx_d = init_idx + 1'b1;
                end
            end
            IDLE: begin
                if (!CE && !WE) begin
                    state_d    = WR_WAIT;
                    wait_cnt_d = WRITE_LOAD;
                    addr_d     = ADDR;
                end else if (!CE && !OE) begin
                    state_d    = RD_FIRST;
                    wait_cnt_d = READ_LOAD;
                    addr_d     = ADDR;
                end
            end
            RD_WAIT, RD_DRIVE: begin
                if (CE) begin
                    state_d = IDLE;
                end else if (!WE) begin
                    state_d    = WR_WAIT;
                    wait_cnt_d = WRITE_LOAD;
                    addr_d     = ADDR;
                end else if (OE) begin
                    state_d = IDLE;
                end else if (ADDR != addr_q) begin
                    state_d    = RD_FIRST;
                    wait_cnt_d = READ_LOAD;
                    addr_d     = ADDR;
                end else if (state == RD_WAIT) begin
                    if (wait_cnt <= 3'd1) begin
                        state_d = RD_DRIVE;
                    end else begin
                        wait_cnt_d = wait_cnt - 3'd1;
                    end
                end
            end
            WR_WAIT: begin
                if (WE || CE) begin
                    state_d = IDLE;
                end else if (wait_cnt == 3'd0) begin
                    commit  = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt - 3'd1;
                end
            end
            WR_HOLD: begin
                if (WE || CE) state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    assign arr_we    = (state == INIT) || commit;
    assign arr_be    = (state == INIT) ? 2'b11 : {~UB, ~LB};
    assign arr_addr  = (state == INIT) ? init_idx : addr_q[DEPTH_W-1:0];
    assign arr_wdata = (state == INIT) ? 16'h0000 : Data;

    sram_array #(
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk     (Clk),
        .wr_en   (arr_we),
        .byte_en (arr_be),
        .addr    (arr_addr),
        .wdata   (arr_wdata),
        .rdata   (arr_rdata)
    );

    // Purely combinational so the bus is released in the same cycle the
    // controller deasserts CE or OE, or asserts WE.
    assign drive = (state == RD_DRIVE) && !CE && !OE && WE;

    assign Data[15:8] = (drive && !UB) ? arr_rdata[15:8] : 8'hzz;
    assign Data[7:0]  = (drive && !LB) ? arr_rdata[7:0]  : 8'hzz;

    assign Rd_valid  = drive && !(UB && LB);
    assign Init_done = (state != INIT);

endmodule
